// File: rtl/defines.vh
// defines.vh: shared default widths and outstanding-depth limits for mem_arb.
`ifndef MEM_ARB_DEFINES_VH
`define MEM_ARB_DEFINES_VH
`define MEM_ARB_N_CH 2
`define MEM_ARB_AW 64
`define MEM_ARB_DW 64
`define MEM_ARB_OUTST 4
`define MEM_ARB_OUTST_MIN 2
`define MEM_ARB_OUTST_MAX 16
`endif

// File: rtl/mem_arb_idq.sv
// mem_arb_idq: synchronous FIFO of channel IDs so responses return to requesters in issue order.
module mem_arb_idq #(
  parameter int W = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // DEPTH is a power of two, so the count MSB alone flags full and pointers wrap for free
  assign full  = cnt_q[PW];
  assign empty = cnt_q == '0;
  assign dout  = mem_q[rd_q];
  assign cnt   = cnt_q;
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d  = wr_q + PW'(do_push);
    rd_d  = rd_q + PW'(do_pop);
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: N_CH-to-1 memory arbiter with in-order response routing.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
`include "defines.vh"
module mem_arb #(
  parameter int N_CH  = `MEM_ARB_N_CH,
  parameter int AW    = `MEM_ARB_AW,
  parameter int DW    = `MEM_ARB_DW,
  parameter int OUTST = `MEM_ARB_OUTST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*AW-1:0]     ch_req_addr,
  input  logic [N_CH*DW-1:0]     ch_req_wdata,
  input  logic [N_CH-1:0]        ch_req_wen,
  input  logic [N_CH-1:0]        ch_req_valid,
  output logic [N_CH-1:0]        ch_req_ready,
  output logic [DW-1:0]          ch_resp_rdata,
  output logic [N_CH-1:0]        ch_resp_valid,
  output logic [AW-1:0]          mem_req_addr,
  output logic [DW-1:0]          mem_req_wdata,
  output logic                   mem_req_wen,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  input  logic [DW-1:0]          mem_resp_rdata,
  input  logic                   mem_resp_valid,
  output logic [$clog2(OUTST):0] outst_cnt,
  output logic                   err
);
  localparam int IW = $clog2(N_CH);
  logic [IW-1:0] g, head;
  logic req_any, full, empty, push, pop;
  logic err_q, err_d;
`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  always_comb begin
    g = '0;
    req_any = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!req_any && ch_req_valid[(int'(ptr_q) + i) % N_CH]) begin
        req_any = 1'b1;
        g = IW'((int'(ptr_q) + i) % N_CH);
      end
    end
    ptr_d = push ? IW'((int'(g) + 1) % N_CH) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
`else
  always_comb begin
    g = '0;
    req_any = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_req_valid[i]) begin
        req_any = 1'b1;
        g = IW'(i);
      end
    end
  end
`endif
  // Full blocks acceptance even when a response pops in the same cycle
  always_comb begin
    mem_req_valid = rst & req_any & ~full;
    push          = mem_req_valid & mem_req_ready;
    pop           = rst & mem_resp_valid & ~empty;
    mem_req_addr  = req_any ? ch_req_addr[int'(g)*AW +: AW] : '0;
    mem_req_wdata = req_any ? ch_req_wdata[int'(g)*DW +: DW] : '0;
    mem_req_wen   = req_any ? ch_req_wen[g] : 1'b0;
    ch_req_ready  = push ? N_CH'(1) << g : '0;
    ch_resp_valid = pop ? N_CH'(1) << head : '0;
    ch_resp_rdata = mem_resp_rdata;
    err_d         = err_q | (mem_resp_valid & empty);
  end
  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign err = err_q;
  mem_arb_idq #(.W(IW), .DEPTH(OUTST)) u_idq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (g),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .cnt   (outst_cnt)
  );
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed and random stimulus for mem_arb checked against a queue-based reference model.
module tb_mem_arb;
  localparam int N = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OUTST = 4;
  localparam int CW = $clog2(OUTST) + 1;
  logic clk = 1'b0;
  logic rst;
  logic [N*AW-1:0] ch_req_addr;
  logic [N*DW-1:0] ch_req_wdata;
  logic [N-1:0] ch_req_wen, ch_req_valid, ch_req_ready, ch_resp_valid;
  logic [DW-1:0] ch_resp_rdata, mem_req_wdata, mem_resp_rdata;
  logic [AW-1:0] mem_req_addr;
  logic mem_req_wen, mem_req_valid, mem_req_ready, mem_resp_valid, err;
  logic [CW-1:0] outst_cnt;
  int q[$];
  int ptr_m = 0;
  bit err_m = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arb #(.N_CH(N), .AW(AW), .DW(DW), .OUTST(OUTST)) dut (
    .clk            (clk),
    .rst            (rst),
    .ch_req_addr    (ch_req_addr),
    .ch_req_wdata   (ch_req_wdata),
    .ch_req_wen     (ch_req_wen),
    .ch_req_valid   (ch_req_valid),
    .ch_req_ready   (ch_req_ready),
    .ch_resp_rdata  (ch_resp_rdata),
    .ch_resp_valid  (ch_resp_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wen    (mem_req_wen),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_rdata (mem_resp_rdata),
    .mem_resp_valid (mem_resp_valid),
    .outst_cnt      (outst_cnt),
    .err            (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs against the model, then advance the model at the edge
  task automatic cycle();
    int g, k;
    bit any, ok, acc, pop;
    #1;
    any = 1'b0;
    g = 0;
    for (int i = 0; i < N; i++) begin
`ifdef MEM_ARB_RR_EN
      k = (ptr_m + i) % N;
`else
      k = i;
`endif
      if (!any && ch_req_valid[k]) begin
        any = 1'b1;
        g = k;
      end
    end
    ok  = rst && any && q.size() < OUTST;
    acc = ok && mem_req_ready;
    pop = rst && mem_resp_valid && q.size() > 0;
    chk("mem_req_valid", mem_req_valid, ok);
    chk("mem_req_addr", mem_req_addr, any ? ch_req_addr[g*AW +: AW] : 0);
    chk("mem_req_wdata", mem_req_wdata, any ? ch_req_wdata[g*DW +: DW] : 0);
    chk("mem_req_wen", mem_req_wen, any ? ch_req_wen[g] : 0);
    chk("ch_req_ready", ch_req_ready, acc ? (1 << g) : 0);
    chk("ch_resp_valid", ch_resp_valid, pop ? (1 << q[0]) : 0);
    chk("ch_resp_rdata", ch_resp_rdata, mem_resp_rdata);
    chk("outst_cnt", outst_cnt, q.size());
    chk("err", err, err_m);
    @(posedge clk);
    if (!rst) begin
      q.delete();
      err_m = 1'b0;
      ptr_m = 0;
    end else begin
      if (mem_resp_valid && q.size() == 0) err_m = 1'b1;
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(g);
        ptr_m = (g + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    ch_req_valid = '0;
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      mem_resp_rdata = $urandom;
      cycle();
    end
    mem_resp_valid = 1'b0;
    #1;
    chk("drain_empty", outst_cnt, 0);
  endtask

  initial begin
    rst = 1'b0;
    ch_req_addr = {32'h2000_0000, 32'h1000_0000};
    ch_req_wdata = {32'hD1D1_D1D1, 32'hD0D0_D0D0};
    ch_req_wen = '0;
    ch_req_valid = '0;
    mem_req_ready = 1'b0;
    mem_resp_rdata = '0;
    mem_resp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cycle();
    #1;
    chk("rst_cnt", outst_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_mvalid", mem_req_valid, 0);
    rst = 1'b1;
    // Two channels contending continuously
    ch_req_valid = 2'b11;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef MEM_ARB_RR_EN
      chk("grant_seq", ch_req_ready, (i % 2) ? 2'b10 : 2'b01);
`else
      chk("grant_seq", ch_req_ready, 2'b01);
`endif
      cycle();
    end
    drain();
    // Fill to OUTST, fifth held until the first response frees a slot
    ch_req_valid = 2'b01;
    repeat (4) cycle();
    #1;
    chk("full_cnt", outst_cnt, 4);
    chk("full_ready", ch_req_ready, 0);
    cycle();
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h1234;
    #1;
    chk("full_pop_blocked", ch_req_ready, 0);
    cycle();
    mem_resp_valid = 1'b0;
    #1;
    chk("fifth_accept", ch_req_ready, 2'b01);
    cycle();
    drain();
    // Read on ch1 then write on ch0; responses route in order
    ch_req_addr = {32'h100, 32'h200};
    ch_req_valid = 2'b10;
    ch_req_wen = 2'b00;
    cycle();
    ch_req_valid = 2'b01;
    ch_req_wen = 2'b01;
    cycle();
    ch_req_valid = '0;
    ch_req_wen = '0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hAA;
    #1;
    chk("order_first", ch_resp_valid, 2'b10);
    chk("order_rdata", ch_resp_rdata, 32'hAA);
    cycle();
    mem_resp_rdata = 32'hBB;
    #1;
    chk("order_second", ch_resp_valid, 2'b01);
    cycle();
    // Stray response with nothing outstanding
    cycle();
    mem_resp_valid = 1'b0;
    #1;
    chk("stray_err", err, 1);
    cycle();
    #1;
    chk("stray_err_sticky", err, 1);
    // Simultaneous push/pop at depth 2, crossing the pointer wrap
    ch_req_valid = 2'b01;
    repeat (2) cycle();
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ch_req_valid = N'(1 + $urandom_range(0, 2));
      ch_req_addr = {$urandom, $urandom};
      mem_resp_rdata = $urandom;
      cycle();
    end
    #1;
    chk("pushpop_cnt", outst_cnt, 2);
    drain();
    // Reset with three outstanding
    ch_req_valid = 2'b01;
    repeat (3) cycle();
    ch_req_valid = '0;
    #1;
    chk("pre_rst_cnt", outst_cnt, 3);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt", outst_cnt, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_mvalid", mem_req_valid, 0);
    mem_resp_valid = 1'b1;
    cycle();
    mem_resp_valid = 1'b0;
    #1;
    chk("late_resp_err", err, 1);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 50) != 0;
      ch_req_valid = N'($urandom);
      ch_req_wen = N'($urandom);
      ch_req_addr = {$urandom, $urandom};
      ch_req_wdata = {$urandom, $urandom};
      mem_req_ready = ($urandom % 4) != 0;
      mem_resp_valid = ($urandom % 3) == 0;
      mem_resp_rdata = $urandom;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of requester channels (2..8).
REQ-002 SHALL have parameter AW, default 64, address width.
REQ-003 SHALL have parameter DW, default 64, data width.
REQ-004 SHALL have parameter OUTST, default 4, max outstanding requests (power of 2, 2..16).
REQ-005 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port ch_req_addr  in  N_CH*AW  per-channel request address, channel i at [i*AW +: AW].
REQ-008 SHALL have port ch_req_wdata  in  N_CH*DW  per-channel write data.
REQ-009 SHALL have port ch_req_wen  in  N_CH  per-channel write enable.
REQ-010 SHALL have port ch_req_valid  in  N_CH  per-channel request valid.
REQ-011 SHALL have port ch_req_ready  out  N_CH  per-channel request accepted.
REQ-012 SHALL have port ch_resp_rdata  out  DW  response data, broadcast to all channels.
REQ-013 SHALL have port ch_resp_valid  out  N_CH  one-hot response strobe to the owning channel.
REQ-014 SHALL have ports mem_req_addr/mem_req_wdata/mem_req_wen/mem_req_valid  out  AW/DW/1/1  downstream request.
REQ-015 SHALL have port mem_req_ready  in  1  downstream accepts request.
REQ-016 SHALL have ports mem_resp_rdata  in  DW  and mem_resp_valid  in  1  downstream response.
REQ-017 SHALL have port outst_cnt  out  $clog2(OUTST)+1  current outstanding count.
REQ-018 SHALL have port err  out  1  sticky flag, response received with no outstanding request.

Function
REQ-019 SHALL grant, each cycle, combinationally at most one channel g among valid channels, per the arbitration policy.
REQ-020 SHALL drive mem_req_valid = |ch_req_valid & !full; mem_req_addr/wdata/wen are the fields of channel g (zero when none).
REQ-021 SHALL assert ch_req_ready[g] only when mem_req_valid & mem_req_ready; all other ready bits 0.
REQ-022 SHALL treat full (outst_cnt == OUTST) as blocking acceptance, even when a response pops in the same cycle.
REQ-023 SHALL push g into an in-order ID queue on each accepted request, reads and writes alike; every request receives exactly one mem_resp_valid.
REQ-024 SHALL, on mem_resp_valid with a non-empty queue, assert ch_resp_valid[head] in the same cycle (0-cycle latency), pass mem_resp_rdata through, and pop.
REQ-025 SHALL, on mem_resp_valid with an empty queue, drive ch_resp_valid = 0, leave the queue unchanged, and set err until reset.
REQ-026 SHALL, on simultaneous push and pop, keep outst_cnt unchanged and preserve order.
REQ-027 SHALL let the queue pointers wrap modulo OUTST without loss.
REQ-028 SHALL hold the grant stable while mem_req_valid is asserted without ready; the pointer does not move on a stalled cycle.

Reset
REQ-029 SHALL, while rst = 0 at a clock edge, clear the queue, outst_cnt = 0, err = 0, and the RR pointer = 0; mem_req_valid, ch_req_ready, and ch_resp_valid are forced to 0 during reset.
REQ-030 SHALL discard in-flight requests on a reset mid-operation; responses arriving afterwards set err.

Configuration
REQ-031 SHALL, with MEM_ARB_RR_EN defined, use round-robin arbitration: search starts at the pointer, and after an accepted grant the pointer = (g+1) mod N_CH.
REQ-032 SHALL, without MEM_ARB_RR_EN, use fixed priority: the lowest-index valid channel wins, and no pointer register exists.

Structure
REQ-033 SHALL place shared constants (default widths, OUTST limits) in defines.vh; no new package.
REQ-034 SHALL implement the ID queue as sub-module mem_arb_idq (synchronous FIFO, width $clog2(N_CH), depth OUTST).

Verification
REQ-035 SHALL cover: ch0 and ch1 valid continuously, mem_req_ready = 1, RR on -> grants 0,1,0,1; RR off -> grants 0,0,0,0.
REQ-036 SHALL cover: 4 reads accepted with no response, OUTST = 4 -> outst_cnt = 4, ch_req_ready = 0; a 5th is held until the 1st response, then accepted in the following cycle.
REQ-037 SHALL cover: ch1 read A = 0x100, then ch0 write B = 0x200; responses 0xAA then 0xBB -> ch_resp_valid = 2'b10 with rdata 0xAA, then 2'b01.
REQ-038 SHALL cover: mem_resp_valid pulse at outst_cnt = 0 -> err = 1 and stays 1, ch_resp_valid = 0.
REQ-039 SHALL cover: same-cycle accept and response at outst_cnt = 2 -> outst_cnt stays 2, order kept across pointer wrap after 20 transactions.
REQ-040 SHALL cover: rst = 0 with 3 outstanding -> next cycle outst_cnt = 0, err = 0, mem_req_valid = 0.
